stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking on every input and on the output. Two grant modes: fixed select (the 4:1 select behaviour extended to N channels and W bits) and round-robin arbitration among valid inputs. It is the datapath selector ahead of shared downstream consumers. It provides one output register stage, tags each beat with its source channel, and sustains full throughput under back-pressure.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `CHANNELS`, 4, number of input channels (≥2)
- `SEL_W`, `$clog2(CHANNELS)`, width of `sel` and `out_chan`; derived, not overridden
- `clk` in 1: the block's one clock; all state updates on its rising edge
- `rst` in 1: reset, synchronous and active-high
- `mode` in 1: 0 = fixed select, 1 = round-robin
- `sel` in SEL_W: channel selected in mode 0; ignored in mode 1
- `in_valid` in CHANNELS: per-channel valid
- `in_data` in CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH]
- `in_ready` out CHANNELS: per-channel ready; one-hot or zero
- `out_valid` out 1: output register holds a beat
- `out_data` out WIDTH: registered data
- `out_chan` out SEL_W: source channel of the held beat
- `out_ready` in 1: downstream accepts the beat

## Operation
- `load = !out_valid || out_ready`, combinational.
- Grant index g:
  - Mode 0: g = `sel` if `sel < CHANNELS` and `in_valid[sel]`. Otherwise there is no grant.
  - Mode 1: g is the first k with `in_valid[k]`, searching cyclically from `ptr` (ptr, ptr+1, …, wrapping CHANNELS-1→0). If no input is valid, there is no grant.
- `in_ready[k] = load && grant_exists && (k == g)`, combinational. At most one bit is set. `in_ready` never depends on unrelated channels' data.
- Input transfer on channel k: `in_valid[k] && in_ready[k]` at a rising edge.
- At a rising edge with `load`:
  - If there is a grant: `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - If there is no grant: `out_valid <= 0`. `out_data` and `out_chan` hold their values.
- With `!load` (`out_valid && !out_ready`): all output registers hold.
- Round-robin pointer `ptr` (internal, SEL_W bits):
  - On an input transfer in mode 1: `ptr <= (g == CHANNELS-1) ? 0 : g+1`.
  - Holds otherwise, including all of mode 0.
- `mode` and `sel` are sampled each cycle. A change takes effect on the next grant decision. A held output beat is never altered.
- Stability: while `out_valid && !out_ready`, `out_data` and `out_chan` are constant.
- Reset (`rst`=1 at an edge) overrides everything: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0. A beat held at that edge is discarded. While `rst` is high, `in_ready` reads 0.

## Timing
- Latency: 1 cycle, from input transfer edge to `out_valid`/`out_data` visible.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Combinational paths: `out_ready`/`in_valid`/`mode`/`sel` → `in_ready`. There is no path from input to `out_*`.
- Simultaneous output accept and new load in the same cycle is required (no bubble).
- Round-robin fairness: a continuously valid channel is granted within CHANNELS transfers.
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0 during reset.

## Test plan
- Reset: `rst`=1 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0. After release, the first grant in mode 1 is channel 0.
- Fixed select, WIDTH=8, CHANNELS=4: `mode`=0, data = {0x44,0x33,0x22,0x11} for ch3..0, all valid, `out_ready`=1, `sel` stepping 0,1,2,3 each cycle → `out_data` = 0x11,0x22,0x33,0x44 one cycle later, `out_chan` = 0,1,2,3. Only `in_ready[sel]` is high. With `sel`=2 and `in_valid[2]`=0 → no transfer and `out_valid`=0.
- Round-robin: `mode`=1, all four valid continuously, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0,1…. With only ch1 and ch3 valid → 1,3,1,3.
- Back-pressure: a beat 0xA5 from ch2 is held with `out_ready`=0 for 5 cycles → `out_data`=0xA5, `out_chan`=2 stable, `in_ready`=0. When `out_ready` rises, the next beat loads on that same edge (no bubble cycle).
- Pointer wrap / sparse valid: CHANNELS=5 (non-power-of-two), mode 1, last grant ch4 → `ptr` wraps to 0. In mode 0, `sel`=5,6,7 → never granted.
- Reset mid-operation: `rst` pulsed while `out_valid`=1 and `out_ready`=0 → beat discarded, `out_valid`=0 next cycle, `ptr`=0.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with fixed-select or round-robin grant.
// One output stage; each beat carries its source channel index.
module stream_mux_n #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load;
  logic                w_fx_hit;
  logic                w_rr_hit;
  logic [SEL_W-1:0]    w_rr_g;
  logic                w_hit;
  logic [SEL_W-1:0]    w_g;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_ready;
  logic [SEL_W-1:0]    w_ptr_nxt;
  int                  w_idx;

  assign w_load = !r_valid || out_ready;

  assign w_fx_hit = (int'(sel) < CHANNELS) && in_valid[sel];

  // Cyclic search starting at r_ptr; r_ptr is always < CHANNELS.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_g   = '0;
    w_idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
      if (!w_rr_hit && in_valid[w_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_g   = SEL_W'(w_idx);
      end
    end
  end

  assign w_hit  = mode ? w_rr_hit : w_fx_hit;
  assign w_g    = mode ? w_rr_g : sel;
  assign w_xfer = w_load && w_hit && !rst;

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_g] = 1'b1;
  end

  assign w_ptr_nxt = (w_g == SEL_W'(CHANNELS - 1)) ?
                     '0 : w_g + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_hit;
        if (w_hit) begin
          r_data <= in_data[w_g*WIDTH +: WIDTH];
          r_chan <= w_g;
        end
      end
      if (w_xfer && mode) r_ptr <= w_ptr_nxt;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: a 4-channel and a 5-channel instance.
module tb_stream_mux_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_mode;
  logic [1:0]  a_sel;
  logic [3:0]  a_iv;
  logic [31:0] a_id;
  logic [3:0]  a_ir;
  logic        a_ov;
  logic [7:0]  a_od;
  logic [1:0]  a_oc;
  logic        a_or;

  logic        b_mode;
  logic [2:0]  b_sel;
  logic [4:0]  b_iv;
  logic [39:0] b_id;
  logic [4:0]  b_ir;
  logic        b_ov;
  logic [7:0]  b_od;
  logic [2:0]  b_oc;
  logic        b_or;

  stream_mux_n #(.WIDTH(8), .CHANNELS(4)) u_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel),
    .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_chan(a_oc),
    .out_ready(a_or)
  );

  stream_mux_n #(.WIDTH(8), .CHANNELS(5)) u_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
    .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_chan(b_oc),
    .out_ready(b_or)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp_13[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1;
    a_mode = 1'b1; a_sel = 2'd0; a_iv = 4'hF;
    a_id = {8'h44, 8'h33, 8'h22, 8'h11}; a_or = 1'b1;
    b_mode = 1'b1; b_sel = 3'd0; b_iv = 5'h00;
    b_id = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0}; b_or = 1'b1;

    tick(); tick();
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_od", 32'(a_od), 32'd0);
    chk("rst_oc", 32'(a_oc), 32'd0);
    chk("rst_ir", 32'(a_ir), 32'd0);

    rst = 1'b0;
    #1 chk("rr_ir0", 32'(a_ir), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_ov", 32'(a_ov), 32'd1);
      chk("rr_chan", 32'(a_oc), 32'(exp_rr[i]));
    end
    chk("rr_data", 32'(a_od), 32'h22);

    rst = 1'b1; tick(); rst = 1'b0;
    a_iv = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr13_chan", 32'(a_oc), 32'(exp_13[i]));
    end

    a_mode = 1'b0; a_iv = 4'hF;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1 chk("fx_ir", 32'(a_ir), 32'(1 << s));
      tick();
      chk("fx_chan", 32'(a_oc), 32'(s));
      chk("fx_data", 32'(a_od), 32'(8'h11 * (s + 1)));
    end
    a_sel = 2'd2; a_iv = 4'b1011;
    #1 chk("fx_noir", 32'(a_ir), 32'd0);
    tick();
    chk("fx_noov", 32'(a_ov), 32'd0);

    a_iv = 4'hF; a_id[23:16] = 8'hA5;
    tick();
    chk("bp_load", 32'(a_od), 32'hA5);
    a_or = 1'b0;
    a_id[23:16] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ir", 32'(a_ir), 32'd0);
      tick();
      chk("bp_ov", 32'(a_ov), 32'd1);
      chk("bp_od", 32'(a_od), 32'hA5);
      chk("bp_oc", 32'(a_oc), 32'd2);
    end
    a_or = 1'b1;
    #1 chk("bp_rel_ir", 32'(a_ir), 32'h4);
    tick();
    chk("bp_nobub_ov", 32'(a_ov), 32'd1);
    chk("bp_nobub_od", 32'(a_od), 32'h5A);

    a_mode = 1'b1;
    tick();
    chk("mr_chan", 32'(a_oc), 32'd0);
    a_or = 1'b0;
    tick();
    rst = 1'b1;
    #1 chk("mr_ir_rst", 32'(a_ir), 32'd0);
    tick();
    chk("mr_ov", 32'(a_ov), 32'd0);
    chk("mr_od", 32'(a_od), 32'd0);
    rst = 1'b0; a_or = 1'b1;
    #1 chk("mr_ptr0", 32'(a_ir), 32'h1);

    b_iv = 5'b10000;
    #1 chk("b_ir4", 32'(b_ir), 32'h10);
    tick();
    chk("b_chan4", 32'(b_oc), 32'd4);
    chk("b_data4", 32'(b_od), 32'hB4);
    b_iv = 5'h1F;
    #1 chk("b_wrap_ir", 32'(b_ir), 32'h01);
    tick();
    chk("b_wrap_chan", 32'(b_oc), 32'd0);

    b_mode = 1'b0;
    for (int s = 5; s < 8; s++) begin
      b_sel = 3'(s);
      #1 chk("b_oor_ir", 32'(b_ir), 32'd0);
      tick();
      chk("b_oor_ov", 32'(b_ov), 32'd0);
    end
    b_sel = 3'd4;
    #1 chk("b_sel4_ir", 32'(b_ir), 32'h10);
    tick();
    chk("b_sel4_chan", 32'(b_oc), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
